// File: rtl/ofdmbbp_rx_capture_pkg.sv
// Shared types and helpers for the receive-path snapshot buffer.
// Holds the state encoding, the packed word width derivation and the missed-trigger saturation limit.
package ofdmbbp_rx_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4
  } cap_state_e;

  localparam logic [15:0] TRIG_SAT = 16'hFFFF;

  function automatic int calc_word_w(input int num_ch, input int data_w);
    return num_ch * 2 * data_w;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == TRIG_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ofdmbbp_capture_ram.sv
// Simple dual-port ring storage: one write port and one registered read port on a single clock.
// The array has no reset; the read register holds its value whenever re_i is low.
module ofdmbbp_capture_ram
  import ofdmbbp_rx_capture_pkg::*;
#(
  parameter int WORD_W     = 48,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_W-1:0]     wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_W-1:0]     rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ofdmbbp_rx_capture.sv
// Triggered multi-channel snapshot buffer: records I/Q into a ring and freezes a window around a trigger.
// The frozen window is streamed out over valid/ready through a RAM-read stage and a registered output stage.
module ofdmbbp_rx_capture
  import ofdmbbp_rx_capture_pkg::*;
#(
  parameter int  NUM_CH     = 2,
  parameter int  DATA_WIDTH = 12,
  parameter int  ADDR_WIDTH = 10,
  localparam int WORD_W     = calc_word_w(NUM_CH, DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [WORD_W-1:0]     in_data,
  input  logic                  trigger,
  input  logic                  cfg_arm,
  input  logic                  cfg_abort,
  input  logic                  cfg_rearm,
  input  logic [ADDR_WIDTH-1:0] cfg_pre_len,
  input  logic [ADDR_WIDTH:0]   cfg_total_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W-1:0]     out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic [2:0]            state,
  output logic                  capture_done,
  output logic [15:0]           trig_missed
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE_L   = (ADDR_WIDTH+1)'(1);

  cap_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH:0]   total_q, total_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic                  ram_vld_q, ram_vld_d;
  logic                  ram_last_q, ram_last_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic [WORD_W-1:0]     out_data_q, out_data_d;
  logic                  done_q, done_d;
  logic [15:0]           missed_q, missed_d;

  logic                  trig_ev, we, re, beat, out_load;
  logic [ADDR_WIDTH:0]   post_len, cnt_inc, total_clamp, tot_m1;
  logic [ADDR_WIDTH-1:0] pre_eff;
  logic [WORD_W-1:0]     ram_rdata;
  cap_state_e            restart_st;

  ofdmbbp_capture_ram #(
    .WORD_W     (WORD_W),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wa_q),
    .wdata_i (in_data),
    .re_i    (re),
    .raddr_i (rp_q),
    .rdata_o (ram_rdata)
  );

  assign trig_ev  = trigger && in_valid;
  assign we       = in_valid && !cfg_abort &&
                    (state_q == ST_FILL || state_q == ST_ARMED || state_q == ST_POST);
  assign post_len = total_q - {1'b0, pre_q};
  assign cnt_inc  = cnt_q + ONE_L;
  assign beat     = out_valid_q && out_ready;
  // The RAM read register doubles as a holding stage, so a new read is only issued once it drains.
  assign out_load = ram_vld_q && (!out_valid_q || out_ready);
  assign re       = (state_q == ST_READ) && !cfg_abort && (cnt_q != total_q) &&
                    (!ram_vld_q || out_load);

  assign total_clamp = (cfg_total_len > DEPTH_L) ? DEPTH_L : cfg_total_len;
  assign tot_m1      = total_clamp - ONE_L;
  assign pre_eff     = ({1'b0, cfg_pre_len} > tot_m1) ? tot_m1[ADDR_WIDTH-1:0] : cfg_pre_len;
  assign restart_st  = (pre_q != '0) ? ST_FILL : ST_ARMED;

  always_comb begin
    state_d     = state_q;
    pre_d       = pre_q;
    total_d     = total_q;
    wa_d        = we ? wa_q + 1'b1 : wa_q;
    rp_d        = re ? rp_q + 1'b1 : rp_q;
    cnt_d       = re ? cnt_inc : cnt_q;
    ram_vld_d   = re ? 1'b1 : (out_load ? 1'b0 : ram_vld_q);
    ram_last_d  = re ? (cnt_inc == total_q) : ram_last_q;
    out_valid_d = out_load ? 1'b1 : (beat ? 1'b0 : out_valid_q);
    out_last_d  = out_load ? ram_last_q : (beat ? 1'b0 : out_last_q);
    out_data_d  = out_load ? ram_rdata : out_data_q;
    done_d      = 1'b0;
    missed_d    = missed_q;

    if (cfg_abort) begin
      state_d     = ST_IDLE;
      ram_vld_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_arm && cfg_total_len != '0) begin
            pre_d   = pre_eff;
            total_d = total_clamp;
            cnt_d   = '0;
            state_d = (pre_eff != '0) ? ST_FILL : ST_ARMED;
          end
        end
        ST_FILL: begin
          if (trig_ev) missed_d = sat_inc16(missed_q);
          if (we) begin
            if (cnt_inc == {1'b0, pre_q}) begin
              state_d = ST_ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_ARMED: begin
          // Trigger sample lands at wa_q as window index pre_q.
          if (trig_ev) begin
            rp_d = wa_q - pre_q;
            if (post_len == ONE_L) begin
              state_d = ST_READ;
              cnt_d   = '0;
            end else begin
              state_d = ST_POST;
              cnt_d   = ONE_L;
            end
          end
        end
        ST_POST: begin
          if (trig_ev) missed_d = sat_inc16(missed_q);
          if (we) begin
            if (cnt_inc == post_len) begin
              state_d = ST_READ;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_READ: begin
          if (trig_ev) missed_d = sat_inc16(missed_q);
          if (beat && out_last_q) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = cfg_rearm ? restart_st : ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pre_q       <= '0;
      total_q     <= '0;
      wa_q        <= '0;
      rp_q        <= '0;
      cnt_q       <= '0;
      ram_vld_q   <= 1'b0;
      ram_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
      missed_q    <= '0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      total_q     <= total_d;
      wa_q        <= wa_d;
      rp_q        <= rp_d;
      cnt_q       <= cnt_d;
      ram_vld_q   <= ram_vld_d;
      ram_last_q  <= ram_last_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
      missed_q    <= missed_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign busy         = (state_q != ST_IDLE);
  assign state        = state_q;
  assign capture_done = done_q;
  assign trig_missed  = missed_q;

endmodule

// File: tb/tb_ofdmbbp_rx_capture.sv
// Directed bench for the snapshot buffer: ramp input, table of capture windows, plus
// rearm/missed-trigger, abort and asynchronous reset sequences.
module tb_ofdmbbp_rx_capture;

  localparam int NCH = 2;
  localparam int DW  = 12;
  localparam int AW  = 6;
  localparam int WW  = NCH * 2 * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data = '0;
  logic          trigger = 1'b0;
  logic          cfg_arm = 1'b0;
  logic          cfg_abort = 1'b0;
  logic          cfg_rearm = 1'b0;
  logic [AW-1:0] cfg_pre_len = '0;
  logic [AW:0]   cfg_total_len = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [WW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic [2:0]    state;
  logic          capture_done;
  logic [15:0]   trig_missed;

  ofdmbbp_rx_capture #(
    .NUM_CH     (NCH),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .trigger       (trigger),
    .cfg_arm       (cfg_arm),
    .cfg_abort     (cfg_abort),
    .cfg_rearm     (cfg_rearm),
    .cfg_pre_len   (cfg_pre_len),
    .cfg_total_len (cfg_total_len),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .state         (state),
    .capture_done  (capture_done),
    .trig_missed   (trig_missed)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int pre;
    int total;
    int trig;
    bit rnd;
    int first;
  } vec_t;

  int            checks = 0;
  int            failures = 0;
  int            smp = 0;
  int            run_base;
  int            done_cnt, read_cyc, vld_cyc;
  int            trig_offs [5];
  logic [WW-1:0] got_d [$];
  bit            got_l [$];
  vec_t          tbl [5];

  // Ramp sample: ch0 I = v, ch0 Q = v+1, ch1 I = v+2, ch1 Q = v+3.
  function automatic logic [WW-1:0] mk(input int v);
    return {12'(v + 3), 12'(v + 2), 12'(v + 1), 12'(v)};
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    smp++;
    in_data = mk(smp);
  endtask

  task automatic run(input int max_cyc, input int target, input bit rnd, input int ab);
    bit            stall;
    logic [WW-1:0] pd;
    logic          pl;
    int            rel;
    run_base = smp;
    done_cnt = 0;
    read_cyc = -1;
    vld_cyc  = -1;
    stall    = 1'b0;
    pd       = '0;
    pl       = 1'b0;
    got_d.delete();
    got_l.delete();
    for (int c = 0; c < max_cyc; c++) begin
      rel       = smp - run_base;
      in_valid  = 1'b1;
      in_data   = mk(smp);
      trigger   = 1'b0;
      for (int k = 0; k < 5; k++) if (trig_offs[k] == rel) trigger = 1'b1;
      cfg_arm   = (c == 0);
      cfg_abort = (c == ab);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      if (state == 3'd4 && read_cyc < 0) read_cyc = c;
      if (out_valid && vld_cyc < 0) vld_cyc = c;
      if (capture_done) begin
        done_cnt++;
        cfg_rearm = 1'b0;
      end
      if (out_valid && out_ready) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      stall = out_valid && !out_ready;
      pd    = out_data;
      pl    = out_last;
      if (target > 0 && done_cnt == target) break;
      tick();
    end
    cfg_arm   = 1'b0;
    cfg_abort = 1'b0;
    trigger   = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic set_trigs(input int a, input int b, input int c, input int d, input int e);
    trig_offs[0] = a; trig_offs[1] = b; trig_offs[2] = c; trig_offs[3] = d; trig_offs[4] = e;
  endtask

  task automatic check_window(input string tag, input int first, input int total);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_state_end"}, state, 3'd0);
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_beats"}, got_d.size(), total);
    chk({tag, "_latency"}, vld_cyc - read_cyc, 2);
    for (int i = 0; i < got_d.size() && i < total; i++) begin
      chk({tag, "_data"}, got_d[i], mk(run_base + first + i));
      chk({tag, "_last"}, got_l[i], (i == total - 1));
    end
    tick();
    chk({tag, "_done_once"}, capture_done, 1'b0);
  endtask

  initial begin
    // pre, total, trigger offset from arm, random ready, expected first ramp offset
    tbl[0] = '{pre: 5,  total: 8,  trig: 67, rnd: 1'b0, first: 62};
    tbl[1] = '{pre: 4,  total: 16, trig: 20, rnd: 1'b0, first: 16};
    tbl[2] = '{pre: 0,  total: 1,  trig: 3,  rnd: 1'b0, first: 3};
    tbl[3] = '{pre: 10, total: 64, trig: 40, rnd: 1'b1, first: 30};
    tbl[4] = '{pre: 20, total: 8,  trig: 30, rnd: 1'b0, first: 23};

    rst = 1'b1;
    tick();
    tick();
    chk("rst_state", state, 3'd0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_capture_done", capture_done, 1'b0);
    chk("rst_trig_missed", trig_missed, 16'd0);
    rst = 1'b0;
    tick();

    // Entry 0 needs the write pointer still at 0 from reset to land the trigger at address 2.
    for (int t = 0; t < 5; t++) begin
      cfg_pre_len   = AW'(tbl[t].pre);
      cfg_total_len = (AW+1)'(tbl[t].total);
      set_trigs(tbl[t].trig, -1, -1, -1, -1);
      run(400, 1, tbl[t].rnd, -1);
      check_window($sformatf("win%0d", t), tbl[t].first, tbl[t].total);
      chk($sformatf("win%0d_missed", t), trig_missed, 16'd0);
    end

    cfg_pre_len   = AW'(3);
    cfg_total_len = '0;
    set_trigs(-1, -1, -1, -1, -1);
    run(2, 0, 1'b0, -1);
    chk("zero_len_state", state, 3'd0);
    chk("zero_len_busy", busy, 1'b0);

    // Missed triggers in FILL, READ and the rearmed FILL; two real captures.
    cfg_rearm     = 1'b1;
    cfg_pre_len   = AW'(4);
    cfg_total_len = (AW+1)'(8);
    set_trigs(2, 15, 22, 30, 40);
    run(300, 2, 1'b0, -1);
    chk("rearm_done", done_cnt, 2);
    chk("rearm_beats", got_d.size(), 16);
    chk("rearm_missed", trig_missed, 16'd3);
    chk("rearm_state_end", state, 3'd0);
    for (int i = 0; i < got_d.size() && i < 16; i++) begin
      chk("rearm_data", got_d[i], mk(run_base + (i < 8 ? 11 + i : 28 + i)));
      chk("rearm_last", got_l[i], (i == 7 || i == 15));
    end
    tick();

    cfg_pre_len   = AW'(2);
    cfg_total_len = (AW+1)'(32);
    set_trigs(10, -1, -1, -1, -1);
    run(15, 0, 1'b0, 14);
    chk("abort_post_state", state, 3'd0);
    chk("abort_post_valid", out_valid, 1'b0);
    chk("abort_post_missed", trig_missed, 16'd3);

    cfg_pre_len   = AW'(0);
    cfg_total_len = (AW+1)'(4);
    set_trigs(3, -1, -1, -1, -1);
    run(4, 0, 1'b0, 3);
    chk("abort_trig_state", state, 3'd0);
    chk("abort_trig_missed", trig_missed, 16'd3);

    cfg_pre_len   = AW'(2);
    cfg_total_len = (AW+1)'(32);
    set_trigs(10, -1, -1, -1, -1);
    run(46, 0, 1'b0, 45);
    chk("abort_read_state", state, 3'd0);
    chk("abort_read_valid", out_valid, 1'b0);
    chk("abort_read_missed", trig_missed, 16'd3);

    cfg_pre_len   = AW'(4);
    cfg_total_len = (AW+1)'(16);
    set_trigs(20, -1, -1, -1, -1);
    run(300, 1, 1'b0, -1);
    check_window("after_abort", 16, 16);

    cfg_pre_len   = AW'(0);
    cfg_total_len = (AW+1)'(32);
    set_trigs(2, -1, -1, -1, -1);
    run(40, 0, 1'b0, -1);
    chk("pre_rst_state", state, 3'd4);
    chk("pre_rst_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_state", state, 3'd0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_data", out_data, '0);
    chk("arst_out_last", out_last, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_trig_missed", trig_missed, 16'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
